// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with load-use hazard detection
// Bubbles on a load-use hazard or flush, keeps halt sticky, and counts hazard bubbles with saturation.
module idex_stage #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            pipe_en,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic            id_uses_rt,
  input  logic [RW-1:0]   id_wsel,
  input  logic            id_regWr,
  input  logic            id_memRd,
  input  logic            id_memWr,
  input  logic            id_halt,
  input  logic [7:0]      id_ctrl,
  input  logic [DW-1:0]   id_rdat1,
  input  logic [DW-1:0]   id_rdat2,
  input  logic [DW-1:0]   id_imm,
  input  logic [DW-1:0]   id_pc4,
  output logic            idex_valid,
  output logic [RW-1:0]   idex_rs,
  output logic [RW-1:0]   idex_rt,
  output logic [RW-1:0]   idex_wsel,
  output logic            idex_regWr,
  output logic            idex_memRd,
  output logic            idex_memWr,
  output logic            idex_halt,
  output logic [7:0]      idex_ctrl,
  output logic [DW-1:0]   idex_rdat1,
  output logic [DW-1:0]   idex_rdat2,
  output logic [DW-1:0]   idex_imm,
  output logic [DW-1:0]   idex_pc4,
  output logic            lu_stall,
  output logic [CNTW-1:0] bubble_cnt
);

  localparam logic [CNTW-1:0] CNT_ONE = 1;

  // Only a load already in EX can cause a hazard, so one bubble always suffices.
  assign lu_stall = idex_valid & idex_memRd & (idex_wsel != '0) & id_valid &
                    ((idex_wsel == id_rs) | (id_uses_rt & (idex_wsel == id_rt)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      idex_valid <= 1'b0;
      idex_rs    <= '0;
      idex_rt    <= '0;
      idex_wsel  <= '0;
      idex_regWr <= 1'b0;
      idex_memRd <= 1'b0;
      idex_memWr <= 1'b0;
      idex_halt  <= 1'b0;
      idex_ctrl  <= '0;
      idex_rdat1 <= '0;
      idex_rdat2 <= '0;
      idex_imm   <= '0;
      idex_pc4   <= '0;
      bubble_cnt <= '0;
    end else if (pipe_en && !idex_halt) begin
      if (flush || lu_stall) begin
        // Data fields are left as-is; clearing the qualified flags is what makes it a bubble.
        idex_valid <= 1'b0;
        idex_regWr <= 1'b0;
        idex_memRd <= 1'b0;
        idex_memWr <= 1'b0;
        idex_halt  <= 1'b0;
        if (!flush && (bubble_cnt != '1)) begin
          bubble_cnt <= bubble_cnt + CNT_ONE;
        end
      end else begin
        idex_valid <= id_valid;
        idex_rs    <= id_rs;
        idex_rt    <= id_rt;
        idex_wsel  <= id_wsel;
        idex_regWr <= id_valid & id_regWr;
        idex_memRd <= id_valid & id_memRd;
        idex_memWr <= id_valid & id_memWr;
        idex_halt  <= id_valid & id_halt;
        idex_ctrl  <= id_ctrl;
        idex_rdat1 <= id_rdat1;
        idex_rdat2 <= id_rdat2;
        idex_imm   <= id_imm;
        idex_pc4   <= id_pc4;
      end
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - scoreboard bench for idex_stage
// A second instance with a 3-bit counter exercises saturation within a short run.
module tb_idex_stage;

  typedef struct packed {
    logic        valid, regwr, memrd, memwr, halt, stall;
    logic [4:0]  wsel, rs, rt;
    logic [7:0]  ctrl;
    logic [31:0] rdat1, rdat2, imm, pc4;
    logic [15:0] cnt;
  } snap_t;

  typedef struct {
    bit          rst, pe, fl, v, ur, rw, mr, mw, h;
    logic [4:0]  rs, rt, ws;
    logic [31:0] d;
    logic        pst;
    bit          full;
    snap_t       e;
  } step_t;

  logic        CLK = 1'b0;
  logic        RST, pipe_en, flush, id_valid, id_uses_rt, id_regWr, id_memRd, id_memWr, id_halt;
  logic [4:0]  id_rs, id_rt, id_wsel;
  logic [7:0]  id_ctrl;
  logic [31:0] id_rdat1, id_rdat2, id_imm, id_pc4;

  logic        idex_valid, idex_regWr, idex_memRd, idex_memWr, idex_halt, lu_stall;
  logic [4:0]  idex_rs, idex_rt, idex_wsel;
  logic [7:0]  idex_ctrl;
  logic [31:0] idex_rdat1, idex_rdat2, idex_imm, idex_pc4;
  logic [15:0] bubble_cnt;

  logic        s_valid, s_regWr, s_memRd, s_memWr, s_halt, s_stall;
  logic [4:0]  s_rs, s_rt, s_wsel;
  logic [7:0]  s_ctrl;
  logic [31:0] s_rdat1, s_rdat2, s_imm, s_pc4;
  logic [2:0]  s_cnt;

  int checks = 0;
  int errors = 0;
  step_t sb[$];

  always #5 CLK = ~CLK;

  idex_stage #(.DW(32), .RW(5), .CNTW(16)) dut (
    .CLK(CLK), .RST(RST), .pipe_en(pipe_en), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_wsel(id_wsel),
    .id_regWr(id_regWr), .id_memRd(id_memRd), .id_memWr(id_memWr), .id_halt(id_halt),
    .id_ctrl(id_ctrl), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_pc4(id_pc4),
    .idex_valid(idex_valid), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_wsel(idex_wsel),
    .idex_regWr(idex_regWr), .idex_memRd(idex_memRd), .idex_memWr(idex_memWr),
    .idex_halt(idex_halt), .idex_ctrl(idex_ctrl), .idex_rdat1(idex_rdat1),
    .idex_rdat2(idex_rdat2), .idex_imm(idex_imm), .idex_pc4(idex_pc4),
    .lu_stall(lu_stall), .bubble_cnt(bubble_cnt)
  );

  idex_stage #(.DW(32), .RW(5), .CNTW(3)) sat (
    .CLK(CLK), .RST(RST), .pipe_en(pipe_en), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_wsel(id_wsel),
    .id_regWr(id_regWr), .id_memRd(id_memRd), .id_memWr(id_memWr), .id_halt(id_halt),
    .id_ctrl(id_ctrl), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_pc4(id_pc4),
    .idex_valid(s_valid), .idex_rs(s_rs), .idex_rt(s_rt), .idex_wsel(s_wsel),
    .idex_regWr(s_regWr), .idex_memRd(s_memRd), .idex_memWr(s_memWr),
    .idex_halt(s_halt), .idex_ctrl(s_ctrl), .idex_rdat1(s_rdat1),
    .idex_rdat2(s_rdat2), .idex_imm(s_imm), .idex_pc4(s_pc4),
    .lu_stall(s_stall), .bubble_cnt(s_cnt)
  );

  function automatic snap_t X(bit v, bit rw, bit mr, bit mw, bit h, bit st,
                              logic [4:0] ws, logic [4:0] rs, logic [4:0] rt,
                              logic [31:0] d, logic [15:0] c);
    snap_t s;
    s.valid = v; s.regwr = rw; s.memrd = mr; s.memwr = mw; s.halt = h; s.stall = st;
    s.wsel = ws; s.rs = rs; s.rt = rt; s.ctrl = d[7:0];
    s.rdat1 = d; s.rdat2 = ~d; s.imm = d + 32'd1; s.pc4 = d + 32'd4; s.cnt = c;
    return s;
  endfunction

  function automatic step_t mk(bit rst, bit pe, bit fl, bit v, logic [4:0] rs, logic [4:0] rt,
                               bit ur, logic [4:0] ws, bit rw, bit mr, bit mw, bit h,
                               logic [31:0] d, logic pst, bit full, snap_t e);
    step_t s;
    s.rst = rst; s.pe = pe; s.fl = fl; s.v = v; s.rs = rs; s.rt = rt; s.ur = ur; s.ws = ws;
    s.rw = rw; s.mr = mr; s.mw = mw; s.h = h; s.d = d; s.pst = pst; s.full = full; s.e = e;
    return s;
  endfunction

  function automatic snap_t mask(bit full);
    snap_t m;
    m = '1;
    if (!full) begin
      m.wsel = '0; m.rs = '0; m.rt = '0; m.ctrl = '0;
      m.rdat1 = '0; m.rdat2 = '0; m.imm = '0; m.pc4 = '0;
    end
    return m;
  endfunction

  function automatic snap_t obs();
    snap_t s;
    s.valid = idex_valid; s.regwr = idex_regWr; s.memrd = idex_memRd; s.memwr = idex_memWr;
    s.halt = idex_halt; s.stall = lu_stall; s.wsel = idex_wsel; s.rs = idex_rs; s.rt = idex_rt;
    s.ctrl = idex_ctrl; s.rdat1 = idex_rdat1; s.rdat2 = idex_rdat2; s.imm = idex_imm;
    s.pc4 = idex_pc4; s.cnt = bubble_cnt;
    return s;
  endfunction

  task automatic apply(step_t s);
    RST = s.rst; pipe_en = s.pe; flush = s.fl; id_valid = s.v; id_rs = s.rs; id_rt = s.rt;
    id_uses_rt = s.ur; id_wsel = s.ws; id_regWr = s.rw; id_memRd = s.mr; id_memWr = s.mw;
    id_halt = s.h; id_ctrl = s.d[7:0]; id_rdat1 = s.d; id_rdat2 = ~s.d;
    id_imm = s.d + 32'd1; id_pc4 = s.d + 32'd4;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    step_t e;
    snap_t o;
    s.push_back(mk(1, 1, 0, 1, 5, 5, 1, 5, 1, 1, 1, 1, 32'hDEADBEEF, 1'bx, 1, '0));
    s.push_back(mk(1, 1, 1, 1, 7, 7, 1, 7, 1, 1, 1, 1, 32'h12345678, 1'b0, 1, '0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); #1;
      if (s[i].pst !== 1'bx) begin
        checks++;
        if (lu_stall !== s[i].pst) begin errors++; $display("FAIL reset[%0d] pre lu_stall got %b want %b", i, lu_stall, s[i].pst); end
      end
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (((o ^ e.e) & mask(e.full)) !== '0) begin errors++; $display("FAIL reset[%0d] got %h want %h", i, o, e.e); end
    end
  endtask

  task automatic test_load_use();
    step_t s[$];
    step_t e;
    snap_t o;
    s.push_back(mk(0, 1, 0, 1, 1, 2, 0, 5, 1, 1, 0, 0, 100, 0, 1, X(1, 1, 1, 0, 0, 0, 5, 1, 2, 100, 0)));
    s.push_back(mk(0, 1, 0, 1, 5, 3, 1, 7, 1, 0, 0, 0, 200, 1, 0, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    s.push_back(mk(0, 1, 0, 1, 5, 3, 1, 7, 1, 0, 0, 0, 200, 0, 1, X(1, 1, 0, 0, 0, 0, 7, 5, 3, 200, 1)));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); #1; checks++;
      if (lu_stall !== s[i].pst) begin errors++; $display("FAIL load_use[%0d] pre lu_stall got %b want %b", i, lu_stall, s[i].pst); end
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (((o ^ e.e) & mask(e.full)) !== '0) begin errors++; $display("FAIL load_use[%0d] got %h want %h", i, o, e.e); end
    end
  endtask

  task automatic test_uses_rt();
    step_t s[$];
    step_t e;
    snap_t o;
    s.push_back(mk(0, 1, 0, 1, 1, 2, 0, 5, 1, 1, 0, 0, 300, 0, 1, X(1, 1, 1, 0, 0, 0, 5, 1, 2, 300, 1)));
    s.push_back(mk(0, 1, 0, 1, 1, 5, 0, 8, 1, 0, 0, 0, 310, 0, 1, X(1, 1, 0, 0, 0, 0, 8, 1, 5, 310, 1)));
    s.push_back(mk(0, 1, 0, 1, 1, 2, 0, 5, 1, 1, 0, 0, 320, 0, 1, X(1, 1, 1, 0, 0, 0, 5, 1, 2, 320, 1)));
    s.push_back(mk(0, 1, 0, 1, 1, 5, 1, 8, 1, 0, 0, 0, 330, 1, 0, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)));
    s.push_back(mk(0, 1, 0, 1, 1, 5, 1, 8, 1, 0, 0, 0, 330, 0, 1, X(1, 1, 0, 0, 0, 0, 8, 1, 5, 330, 2)));
    s.push_back(mk(0, 1, 0, 1, 1, 2, 0, 0, 1, 1, 0, 0, 340, 0, 1, X(1, 1, 1, 0, 0, 0, 0, 1, 2, 340, 2)));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 1, 9, 1, 0, 0, 0, 350, 0, 1, X(1, 1, 0, 0, 0, 0, 9, 0, 0, 350, 2)));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); #1; checks++;
      if (lu_stall !== s[i].pst) begin errors++; $display("FAIL uses_rt[%0d] pre lu_stall got %b want %b", i, lu_stall, s[i].pst); end
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (((o ^ e.e) & mask(e.full)) !== '0) begin errors++; $display("FAIL uses_rt[%0d] got %h want %h", i, o, e.e); end
    end
  endtask

  task automatic test_pipe_hold();
    step_t s[$];
    step_t e;
    snap_t o;
    s.push_back(mk(0, 1, 0, 1, 1, 2, 0, 5, 1, 1, 0, 0, 400, 0, 1, X(1, 1, 1, 0, 0, 0, 5, 1, 2, 400, 2)));
    for (int k = 0; k < 3; k++)
      s.push_back(mk(0, 0, 0, 1, 5, 3, 0, 9, 1, 0, 0, 0, 410, 1, 1, X(1, 1, 1, 0, 0, 1, 5, 1, 2, 400, 2)));
    s.push_back(mk(0, 1, 0, 1, 5, 3, 0, 9, 1, 0, 0, 0, 410, 1, 0, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3)));
    s.push_back(mk(0, 1, 0, 1, 5, 3, 0, 9, 1, 0, 0, 0, 410, 0, 1, X(1, 1, 0, 0, 0, 0, 9, 5, 3, 410, 3)));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); #1; checks++;
      if (lu_stall !== s[i].pst) begin errors++; $display("FAIL pipe_hold[%0d] pre lu_stall got %b want %b", i, lu_stall, s[i].pst); end
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (((o ^ e.e) & mask(e.full)) !== '0) begin errors++; $display("FAIL pipe_hold[%0d] got %h want %h", i, o, e.e); end
    end
  endtask

  task automatic test_flush_stall();
    step_t s[$];
    step_t e;
    snap_t o;
    s.push_back(mk(0, 1, 0, 1, 1, 2, 0, 5, 1, 1, 0, 0, 500, 0, 1, X(1, 1, 1, 0, 0, 0, 5, 1, 2, 500, 3)));
    s.push_back(mk(0, 1, 1, 1, 5, 3, 0, 9, 1, 0, 0, 0, 510, 1, 0, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3)));
    s.push_back(mk(0, 1, 0, 1, 5, 3, 0, 9, 1, 0, 0, 0, 510, 0, 1, X(1, 1, 0, 0, 0, 0, 9, 5, 3, 510, 3)));
    s.push_back(mk(0, 1, 1, 1, 1, 2, 0, 9, 1, 0, 1, 0, 520, 0, 0, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3)));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); #1; checks++;
      if (lu_stall !== s[i].pst) begin errors++; $display("FAIL flush_stall[%0d] pre lu_stall got %b want %b", i, lu_stall, s[i].pst); end
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (((o ^ e.e) & mask(e.full)) !== '0) begin errors++; $display("FAIL flush_stall[%0d] got %h want %h", i, o, e.e); end
    end
  endtask

  task automatic test_halt();
    step_t s[$];
    step_t e;
    snap_t o;
    s.push_back(mk(0, 1, 0, 0, 1, 2, 0, 5, 1, 1, 1, 1, 590, 0, 0, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3)));
    s.push_back(mk(0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 1, 600, 0, 1, X(1, 0, 0, 0, 1, 0, 0, 1, 2, 600, 3)));
    s.push_back(mk(0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 1, 0, 610, 0, 1, X(1, 0, 0, 0, 1, 0, 0, 1, 2, 600, 3)));
    s.push_back(mk(0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 610, 0, 1, X(1, 0, 0, 0, 1, 0, 0, 1, 2, 600, 3)));
    s.push_back(mk(1, 1, 0, 1, 1, 2, 0, 0, 0, 0, 1, 0, 610, 0, 1, '0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); #1; checks++;
      if (lu_stall !== s[i].pst) begin errors++; $display("FAIL halt[%0d] pre lu_stall got %b want %b", i, lu_stall, s[i].pst); end
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (((o ^ e.e) & mask(e.full)) !== '0) begin errors++; $display("FAIL halt[%0d] got %h want %h", i, o, e.e); end
    end
  endtask

  task automatic test_saturation();
    step_t s[$];
    step_t e;
    snap_t o;
    logic [2:0] want_sat;
    for (int k = 0; k < 10; k++) begin
      s.push_back(mk(0, 1, 0, 1, 5, 0, 0, 5, 1, 1, 0, 0, 800 + k, 0, 1,
                     X(1, 1, 1, 0, 0, 1, 5, 5, 0, 800 + k, 16'(k))));
      s.push_back(mk(0, 1, 0, 1, 5, 0, 0, 5, 1, 1, 0, 0, 800 + k, 1, 0,
                     X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'(k + 1))));
    end
    s.push_back(mk(0, 1, 0, 1, 5, 0, 0, 5, 1, 1, 0, 0, 900, 0, 1, X(1, 1, 1, 0, 0, 1, 5, 5, 0, 900, 10)));
    s.push_back(mk(1, 1, 0, 1, 5, 0, 0, 5, 1, 1, 0, 0, 900, 1, 1, '0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); #1; checks++;
      if (lu_stall !== s[i].pst) begin errors++; $display("FAIL saturation[%0d] pre lu_stall got %b want %b", i, lu_stall, s[i].pst); end
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (((o ^ e.e) & mask(e.full)) !== '0) begin errors++; $display("FAIL saturation[%0d] got %h want %h", i, o, e.e); end
      want_sat = (e.e.cnt > 16'd7) ? 3'd7 : e.e.cnt[2:0];
      checks++;
      if (s_cnt !== want_sat) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, s_cnt, want_sat); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_uses_rt();
    test_pipe_hold();
    test_flush_stall();
    test_halt();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
